// File: rtl/alu_sched.sv
`default_nettype none
// ============================================================================
// Module   : alu_sched
// Purpose  : Round-robin scheduler sharing one fixed 2-cycle-latency ALU among
//            NREQ requesters, with halt/drain control and result routing.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sched #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  halt,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_in0,
    input  logic [NREQ*WIDTH-1:0] req_in1,
    input  logic [NREQ*3-1:0]     req_opcode,
    output logic [WIDTH-1:0]      alu_in0,
    output logic [WIDTH-1:0]      alu_in1,
    output logic [2:0]            alu_opcode,
    input  logic [WIDTH-1:0]      alu_out,
    input  logic                  alu_overflow,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_overflow,
    output logic                  halted
);

    localparam int         PTR_W       = $clog2(NREQ);
    localparam int         IDX_W       = PTR_W + 1;
    localparam logic [2:0] OVF_LAST_OP = 3'b100;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              s1_valid_q, s1_valid_d, s2_valid_q;
    logic [PTR_W-1:0]  s1_id_q, s1_id_d, s2_id_q;
    logic [2:0]        s1_op_q, s1_op_d, s2_op_q;

    logic              grant_en;
    logic              xfer;
    logic [PTR_W-1:0]  gnt_id;

    // Descending scan so the requester closest to rr_ptr is written last and wins.
    always_comb begin : arbiter
        logic [IDX_W-1:0] idx;
        idx      = '0;
        grant_en = rst_n && (state_q == ST_RUN) && !halt;
        xfer     = 1'b0;
        gnt_id   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_q} + IDX_W'(k);
            if (idx >= IDX_W'(NREQ)) begin
                idx = idx - IDX_W'(NREQ);
            end
            if (req_valid[idx[PTR_W-1:0]]) begin
                xfer   = grant_en;
                gnt_id = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin : issue
        req_ready  = '0;
        alu_in0    = '0;
        alu_in1    = '0;
        alu_opcode = 3'b000;
        if (xfer) begin
            req_ready[gnt_id] = 1'b1;
            alu_in0           = req_in0[int'(gnt_id)*WIDTH +: WIDTH];
            alu_in1           = req_in1[int'(gnt_id)*WIDTH +: WIDTH];
            alu_opcode        = req_opcode[int'(gnt_id)*3 +: 3];
        end
    end

    always_comb begin : next_state
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        s1_valid_d = xfer;
        s1_id_d    = gnt_id;
        s1_op_d    = alu_opcode;
        if (xfer) begin
            rr_ptr_d = (gnt_id == PTR_W'(NREQ - 1)) ? '0 : gnt_id + PTR_W'(1);
        end
        // Stage 2 retires this cycle, so an empty stage 1 means nothing is left after the edge.
        case (state_q)
            ST_RUN:    if (halt) state_d = ST_DRAIN;
            ST_DRAIN:  if (!halt) state_d = ST_RUN;
                       else if (!s1_valid_q) state_d = ST_HALTED;
            ST_HALTED: if (!halt) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            rr_ptr_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_op_q    <= 3'b000;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_op_q    <= 3'b000;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s1_valid_q;
            s2_id_q    <= s1_id_q;
            s2_op_q    <= s1_op_q;
        end
    end

    always_comb begin : respond
        rsp_valid    = '0;
        rsp_data     = '0;
        rsp_overflow = 1'b0;
        if (rst_n && s2_valid_q) begin
            rsp_valid[s2_id_q] = 1'b1;
            rsp_data           = alu_out;
            rsp_overflow       = alu_overflow && (s2_op_q <= OVF_LAST_OP);
        end
    end

    assign halted = rst_n && (state_q == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_alu_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sched
// Purpose  : Self-checking bench for alu_sched with a 2-cycle ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sched;

    localparam int WIDTH    = 16;
    localparam int NREQ     = 4;
    localparam int M_RUN    = 0;
    localparam int M_DRAIN  = 1;
    localparam int M_HALTED = 2;

    logic                  clk = 1'b0;
    logic                  rst_n, halt;
    logic [NREQ-1:0]       req_valid, req_ready, rsp_valid;
    logic [NREQ*WIDTH-1:0] req_in0, req_in1;
    logic [NREQ*3-1:0]     req_opcode;
    logic [WIDTH-1:0]      alu_in0, alu_in1, alu_out, rsp_data;
    logic [2:0]            alu_opcode;
    logic                  alu_overflow, rsp_overflow, halted;
    logic [WIDTH:0]        alu_p1, alu_p2;

    typedef struct {
        int               due;
        int               id;
        logic [WIDTH-1:0] data;
        logic             ovf;
    } exp_t;

    exp_t             q[$];
    int               m_ptr = 0, m_mode = M_RUN, m_g = -1, cyc = 0;
    int               n_cmp = 0, n_err = 0;
    logic [NREQ-1:0]  e_ready, e_rv;
    logic [WIDTH-1:0] e_in0, e_in1, e_rd;
    logic [2:0]       e_op;
    logic             e_ro, e_halted;

    always #5 clk = ~clk;

    alu_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in0(req_in0), .req_in1(req_in1), .req_opcode(req_opcode),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_overflow(rsp_overflow),
        .halted(halted)
    );

    // ALU environment: returns {overflow, result}; upper opcodes raise overflow freely.
    function automatic logic [WIDTH:0] alu_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [2:0] op);
        logic [WIDTH-1:0] t;
        logic             o;
        case (op)
            3'd0: return {1'b0, a} + {1'b0, b};
            3'd1: return {1'b0, a} - {1'b0, b};
            3'd2: begin t = a & b; o = t[WIDTH-1]; end
            3'd3: begin t = a | b; o = t[WIDTH-1]; end
            3'd4: begin t = a ^ b; o = t[WIDTH-1]; end
            3'd5: begin t = a << 1; o = a[WIDTH-1]; end
            3'd6: begin t = a >> 1; o = a[0]; end
            default: begin t = (a == b) ? WIDTH'(1) : '0; o = 1'b1; end
        endcase
        return {o, t};
    endfunction

    always @(posedge clk) begin
        alu_p1 <= alu_ref(alu_in0, alu_in1, alu_opcode);
        alu_p2 <= alu_p1;
    end
    assign alu_out      = alu_p2[WIDTH-1:0];
    assign alu_overflow = alu_p2[WIDTH];

    task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [2:0] op);
        req_in0[i*WIDTH +: WIDTH] = a;
        req_in1[i*WIDTH +: WIDTH] = b;
        req_opcode[i*3 +: 3]      = op;
    endtask

    // Expected outputs for the current cycle from the scheduling rules.
    task automatic model_eval();
        int idx;
        m_g = -1;
        if (rst_n && m_mode == M_RUN && !halt) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (m_g < 0 && req_valid[idx]) m_g = idx;
            end
        end
        e_ready = '0; e_in0 = '0; e_in1 = '0; e_op = 3'b000;
        if (m_g >= 0) begin
            e_ready[m_g] = 1'b1;
            e_in0 = req_in0[m_g*WIDTH +: WIDTH];
            e_in1 = req_in1[m_g*WIDTH +: WIDTH];
            e_op  = req_opcode[m_g*3 +: 3];
        end
        e_rv = '0; e_rd = '0; e_ro = 1'b0;
        if (rst_n && q.size() > 0 && q[0].due == cyc) begin
            e_rv[q[0].id] = 1'b1;
            e_rd = q[0].data;
            e_ro = q[0].ovf;
        end
        e_halted = rst_n && (m_mode == M_HALTED);
    endtask

    task automatic tick();
        logic [WIDTH:0] r;
        model_eval();
        @(posedge clk);
        if (!rst_n) begin
            m_ptr = 0; m_mode = M_RUN; q.delete();
        end else begin
            if (m_g >= 0) begin
                r = alu_ref(e_in0, e_in1, e_op);
                q.push_back('{due: cyc + 2, id: m_g, data: r[WIDTH-1:0],
                              ovf: (e_op <= 3'd4) ? r[WIDTH] : 1'b0});
                m_ptr = (m_g + 1) % NREQ;
            end
            while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
            case (m_mode)
                M_RUN:   if (halt) m_mode = M_DRAIN;
                M_DRAIN: if (!halt) m_mode = M_RUN; else if (q.size() == 0) m_mode = M_HALTED;
                default: if (!halt) m_mode = M_RUN;
            endcase
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; halt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            req_valid = NREQ'($urandom) | NREQ'(1);
            req_in0 = {$urandom, $urandom}; req_in1 = {$urandom, $urandom}; req_opcode = 12'($urandom);
            @(negedge clk);
            n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL reset_ready: got %b want 0", req_ready); end
            n_cmp++; if ({alu_in0, alu_in1, alu_opcode} !== '0) begin n_err++; $display("FAIL reset_alu: got %h/%h/%b want 0", alu_in0, alu_in1, alu_opcode); end
            n_cmp++; if ({rsp_valid, rsp_data, rsp_overflow, halted} !== '0) begin n_err++; $display("FAIL reset_rsp: got v=%b d=%h o=%b h=%b want 0", rsp_valid, rsp_data, rsp_overflow, halted); end
            tick();
        end
        rst_n = 1'b1; req_valid = '0;
        tick();
    endtask

    task automatic test_single_op();
        req_valid = 4'b0001; set_req(0, 3, 5, 3'b000);
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        n_cmp++; if ({alu_in0, alu_in1, alu_opcode} !== {16'd3, 16'd5, 3'b000}) begin n_err++; $display("FAIL single_alu: got %0d/%0d/%b want 3/5/000", alu_in0, alu_in1, alu_opcode); end
        tick();
        req_valid = '0;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== '0) begin n_err++; $display("FAIL single_early: got %b want 0", rsp_valid); end
        tick();
        @(negedge clk);
        n_cmp++; if ({rsp_valid, rsp_data, rsp_overflow} !== {4'b0001, 16'd8, 1'b0}) begin n_err++; $display("FAIL single_rsp: got v=%b d=%0d o=%b want 0001/8/0", rsp_valid, rsp_data, rsp_overflow); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [WIDTH:0]   r;
        logic [NREQ-1:0]  w;
        int               id;
        rst_n = 1'b0; req_valid = '0; tick(); rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'($urandom), WIDTH'($urandom), 3'($urandom));
        for (int k = 0; k < 7; k++) begin
            req_valid = (k < 5) ? '1 : '0;
            @(negedge clk);
            w = (k < 5) ? NREQ'(1) << (k % NREQ) : '0;
            n_cmp++; if (req_ready !== w) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, w); end
            if (k >= 2) begin
                id = (k - 2) % NREQ;
                r  = alu_ref(req_in0[id*WIDTH +: WIDTH], req_in1[id*WIDTH +: WIDTH], req_opcode[id*3 +: 3]);
                if (req_opcode[id*3 +: 3] > 3'd4) r[WIDTH] = 1'b0;
                w  = NREQ'(1) << id;
                n_cmp++; if ({rsp_valid, rsp_overflow, rsp_data} !== {w, r}) begin n_err++; $display("FAIL rr_rsp[%0d]: got v=%b o=%b d=%h want %b/%b/%h", k, rsp_valid, rsp_overflow, rsp_data, w, r[WIDTH], r[WIDTH-1:0]); end
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        req_valid = 4'b0100; set_req(2, '1, 1, 3'b000);
        @(negedge clk); tick();
        set_req(2, 2, 2, 3'b111);
        @(negedge clk); tick();
        req_valid = '0;
        @(negedge clk);
        n_cmp++; if ({rsp_valid, rsp_data, rsp_overflow} !== {4'b0100, 16'd0, 1'b1}) begin n_err++; $display("FAIL ovf_add: got v=%b d=%h o=%b want 0100/0000/1", rsp_valid, rsp_data, rsp_overflow); end
        tick();
        @(negedge clk);
        n_cmp++; if ({rsp_valid, rsp_data, rsp_overflow} !== {4'b0100, 16'd1, 1'b0}) begin n_err++; $display("FAIL ovf_masked: got v=%b d=%h o=%b want 0100/0001/0", rsp_valid, rsp_data, rsp_overflow); end
        tick();
    endtask

    task automatic test_halt_drain();
        req_valid = 4'b0010; halt = 1'b0; set_req(1, WIDTH'($urandom), WIDTH'($urandom), 3'($urandom));
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL halt_first: got %b want 0010", req_ready); end
        tick();
        halt = 1'b1;
        @(negedge clk);
        n_cmp++; if ({req_ready, alu_in0, alu_in1, alu_opcode} !== '0) begin n_err++; $display("FAIL halt_block: got r=%b alu=%h/%h/%b want 0", req_ready, alu_in0, alu_in1, alu_opcode); end
        tick();
        @(negedge clk);
        n_cmp++; if ({rsp_valid, halted} !== {4'b0010, 1'b0}) begin n_err++; $display("FAIL halt_inflight: got v=%b h=%b want 0010/0", rsp_valid, halted); end
        tick();
        @(negedge clk);
        n_cmp++; if ({rsp_valid, req_ready, halted} !== {8'h00, 1'b1}) begin n_err++; $display("FAIL halt_halted: got v=%b r=%b h=%b want 0/0/1", rsp_valid, req_ready, halted); end
        tick();
        halt = 1'b0;
        @(negedge clk);
        n_cmp++; if ({req_ready, halted} !== {4'b0000, 1'b1}) begin n_err++; $display("FAIL halt_release: got r=%b h=%b want 0000/1", req_ready, halted); end
        tick();
        @(negedge clk);
        n_cmp++; if ({req_ready, halted} !== {4'b0010, 1'b0}) begin n_err++; $display("FAIL halt_resume: got r=%b h=%b want 0010/0", req_ready, halted); end
        tick();
        req_valid = '0; tick(); tick();
    endtask

    task automatic test_reset_midflight();
        req_valid = 4'b1000; set_req(3, WIDTH'($urandom), WIDTH'($urandom), 3'($urandom));
        @(negedge clk);
        n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL rstmid_grant: got %b want 1000", req_ready); end
        tick();
        req_valid = '0;
        for (int k = 1; k <= 3; k++) begin
            rst_n = (k != 1);
            if (k == 3) req_valid = '1;
            @(negedge clk);
            n_cmp++; if (rsp_valid !== '0) begin n_err++; $display("FAIL rstmid_rsp[T+%0d]: got %b want 0", k, rsp_valid); end
            if (k == 3) begin
                n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rstmid_ptr: got %b want 0001", req_ready); end
            end
            tick();
        end
        req_valid = '0; tick(); tick();
    endtask

    task automatic test_skip_idle();
        req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) req_valid = 4'b0011;
            @(negedge clk);
            n_cmp++; if (req_ready !== ((k == 2) ? 4'b0010 : 4'b0001)) begin n_err++; $display("FAIL skip_idle[%0d]: got %b want %b", k, req_ready, (k == 2) ? 4'b0010 : 4'b0001); end
            tick();
        end
        req_valid = '0; tick(); tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst_n     = ($urandom_range(0, 79) != 0);
            halt      = ($urandom_range(0, 11) == 0) ? ~halt : halt;
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) set_req(i, WIDTH'($urandom), WIDTH'($urandom), 3'($urandom));
            if ($urandom_range(0, 3) == 0) set_req(int'($urandom_range(0, NREQ - 1)), '1, '1, 3'($urandom_range(0, 1)));
            @(negedge clk);
            model_eval();
            n_cmp++; if (req_ready !== e_ready) begin n_err++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, req_ready, e_ready); end
            n_cmp++; if ({alu_in0, alu_in1, alu_opcode} !== {e_in0, e_in1, e_op}) begin n_err++; $display("FAIL rnd_alu@%0d: got %h/%h/%b want %h/%h/%b", cyc, alu_in0, alu_in1, alu_opcode, e_in0, e_in1, e_op); end
            n_cmp++; if (rsp_valid !== e_rv) begin n_err++; $display("FAIL rnd_rsp_valid@%0d: got %b want %b", cyc, rsp_valid, e_rv); end
            n_cmp++; if ({rsp_data, rsp_overflow} !== {e_rd, e_ro}) begin n_err++; $display("FAIL rnd_rsp_data@%0d: got %h/%b want %h/%b", cyc, rsp_data, rsp_overflow, e_rd, e_ro); end
            n_cmp++; if (halted !== e_halted) begin n_err++; $display("FAIL rnd_halted@%0d: got %b want %b", cyc, halted, e_halted); end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; halt = 1'b0; req_valid = '0;
        req_in0 = '0; req_in1 = '0; req_opcode = '0;
        test_reset();
        test_single_op();
        test_round_robin();
        test_overflow();
        test_halt_drain();
        test_reset_midflight();
        test_skip_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
